// File: rtl/toast_mem_arbiter_pkg.sv
// Shared types and defaults for the ToastCore unified-memory arbiter.
// Owner encoding tags which port, if any, is due the next read response.
package toast_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_I    = 2'd1,
        OWNER_D    = 2'd2
    } mem_owner_t;

    localparam int DEFAULT_STARVE_LIMIT = 4;
    localparam int STARVE_CNT_W         = 4;

endpackage

// File: rtl/toast_mem_arbiter_if.sv
// Bundle of fetch port, data port and RAM-side signals around the arbiter.
// slave = arbiter view; master = core plus RAM view.
interface toast_mem_arbiter_if #(
    parameter int MEM_AW = 14
) ();
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;

    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              addr_err;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output addr_err
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  addr_err
    );
endinterface

// File: rtl/toast_starve_counter.sv
// Saturating count of consecutive cycles a pending fetch has been denied.
// o_at_limit hands priority to the fetch port.
module toast_starve_counter
    import toast_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = DEFAULT_STARVE_LIMIT,
    parameter int CW    = STARVE_CNT_W
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT_C)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_limit = (r_cnt == LIMIT_C);
endmodule

// File: rtl/toast_mem_arbiter.sv
// Single-port RAM arbiter for ToastCore: data port wins unless a fetch has
// starved for STARVE_LIMIT cycles; read data returns one cycle after grant.
module toast_mem_arbiter
    import toast_mem_arbiter_pkg::*;
#(
    parameter int MEM_AW       = 14,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic i_clk,
    input  logic i_reset,
    toast_mem_arbiter_if.slave bus
);
    logic        w_at_limit;
    logic        w_gnt_i;
    logic        w_gnt_d;
    logic        w_gnt_any;
    logic        w_oor_i;
    logic        w_oor_d;
    logic        w_oor;
    logic        w_i_rvalid;
    logic        w_d_rvalid;
    logic [31:0] w_resp_data;
    mem_owner_t  w_owner_nxt;

    mem_owner_t  r_owner;
    logic        r_resp_oor;
    logic        r_addr_err;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    assign w_oor_i = |bus.i_addr[31:MEM_AW+2];
    assign w_oor_d = |bus.d_addr[31:MEM_AW+2];

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign w_gnt_d   = !i_reset && bus.d_req && !(bus.i_req && w_at_limit);
    assign w_gnt_i   = !i_reset && bus.i_req && !w_gnt_d;
    assign w_gnt_any = w_gnt_i || w_gnt_d;
    assign w_oor     = w_gnt_d ? w_oor_d : w_oor_i;

    toast_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CW    (STARVE_CNT_W)
    ) u_starve (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_inc      (bus.i_req && !w_gnt_i),
        .i_clr      (w_gnt_i || !bus.i_req),
        .o_at_limit (w_at_limit)
    );

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (w_gnt_d) begin
            bus.mem_addr = bus.d_addr[MEM_AW+1:2];
            if (!w_oor_d) begin
                bus.mem_en = 1'b1;
                if (bus.d_we) begin
                    bus.mem_we    = bus.d_be;
                    bus.mem_wdata = bus.d_wdata;
                end
            end
        end else if (w_gnt_i) begin
            bus.mem_addr = bus.i_addr[MEM_AW+1:2];
            bus.mem_en   = !w_oor_i;
        end
    end

    always_comb begin
        w_owner_nxt = OWNER_NONE;
        if (w_gnt_i) begin
            w_owner_nxt = OWNER_I;
        end else if (w_gnt_d && !bus.d_we) begin
            w_owner_nxt = OWNER_D;
        end
    end

    assign w_i_rvalid  = !i_reset && (r_owner == OWNER_I);
    assign w_d_rvalid  = !i_reset && (r_owner == OWNER_D);
    assign w_resp_data = r_resp_oor ? 32'h0 : bus.mem_rdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_owner    <= OWNER_NONE;
            r_resp_oor <= 1'b0;
            r_addr_err <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_resp_oor <= w_gnt_any && w_oor;
            r_addr_err <= w_gnt_any && w_oor;
            if (w_i_rvalid) begin
                r_i_rdata <= w_resp_data;
            end
            if (w_d_rvalid) begin
                r_d_rdata <= w_resp_data;
            end
        end
    end

    // RAM data is live only in the response cycle; the hold registers keep it after.
    assign bus.i_gnt    = w_gnt_i;
    assign bus.d_gnt    = w_gnt_d;
    assign bus.i_rvalid = w_i_rvalid;
    assign bus.d_rvalid = w_d_rvalid;
    assign bus.i_rdata  = i_reset ? 32'h0 : (w_i_rvalid ? w_resp_data : r_i_rdata);
    assign bus.d_rdata  = i_reset ? 32'h0 : (w_d_rvalid ? w_resp_data : r_d_rdata);
    assign bus.addr_err = !i_reset && r_addr_err;
endmodule

// File: tb/tb_toast_mem_arbiter.sv
// Directed bench for toast_mem_arbiter with a behavioural byte-writable RAM.
// Inputs change 1 ns after the rising edge; all outputs are checked on the falling edge.
module tb_toast_mem_arbiter;
    localparam int MEM_AW = 14;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [31:0] ram [0:(1<<MEM_AW)-1];
    logic        bd_we;
    logic [MEM_AW-1:0] bd_addr;
    logic [31:0] bd_data;
    logic        prev_d;

    toast_mem_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

    toast_mem_arbiter #(
        .MEM_AW       (MEM_AW),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM returning the pre-write contents; backdoor port preloads it.
    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (bus.mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        prev_d   = 1'b0;
        rst      = 1'b1;
        bus.mem_rdata = 32'h0;
        bd_we    = 1'b1;
        bd_addr  = 14'd4;
        bd_data  = 32'hDEADBEEF;
        // Requests during reset must not reach the RAM.
        bus.i_req   = 1'b1;
        bus.i_addr  = 32'h0000_0010;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'hF;
        bus.d_addr  = 32'h0000_2004;
        bus.d_wdata = 32'hFFFF_FFFF;

        cyc();
        bd_addr = 14'h801;
        bd_data = 32'h0;
        settle();
        check("rst_i_gnt",    bus.i_gnt,    0);
        check("rst_d_gnt",    bus.d_gnt,    0);
        check("rst_mem_en",   bus.mem_en,   0);
        check("rst_mem_we",   bus.mem_we,   0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_i_rvalid", bus.i_rvalid, 0);
        check("rst_d_rvalid", bus.d_rvalid, 0);
        check("rst_i_rdata",  bus.i_rdata,  0);
        check("rst_d_rdata",  bus.d_rdata,  0);
        check("rst_addr_err", bus.addr_err, 0);

        // Fetch of word 4.
        cyc();
        bd_we = 1'b0;
        rst = 1'b0;
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        bus.d_be  = 4'h0;
        settle();
        check("f1_i_gnt",    bus.i_gnt,    1);
        check("f1_d_gnt",    bus.d_gnt,    0);
        check("f1_mem_en",   bus.mem_en,   1);
        check("f1_mem_addr", bus.mem_addr, 32'h4);
        check("f1_mem_we",   bus.mem_we,   0);
        cyc();
        bus.i_req = 1'b0;
        settle();
        check("f1_i_rvalid", bus.i_rvalid, 1);
        check("f1_i_rdata",  bus.i_rdata,  32'hDEADBEEF);
        check("f1_d_rvalid", bus.d_rvalid, 0);
        cyc();
        settle();
        check("f1_i_rvalid_off", bus.i_rvalid, 0);
        check("f1_i_rdata_hold", bus.i_rdata,  32'hDEADBEEF);

        // Partial write, middle two lanes.
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0110;
        bus.d_addr = 32'h0000_2004; bus.d_wdata = 32'h1122_3344;
        settle();
        check("w_d_gnt",     bus.d_gnt,     1);
        check("w_mem_en",    bus.mem_en,    1);
        check("w_mem_we",    bus.mem_we,    32'h6);
        check("w_mem_addr",  bus.mem_addr,  32'h801);
        check("w_mem_wdata", bus.mem_wdata, 32'h1122_3344);
        cyc();
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
        settle();
        check("w_no_d_rvalid", bus.d_rvalid, 0);
        check("w_no_addr_err", bus.addr_err, 0);
        cyc();
        bus.d_req = 1'b1;
        settle();
        check("r_d_gnt",  bus.d_gnt,  1);
        check("r_mem_we", bus.mem_we, 0);
        cyc();
        bus.d_req = 1'b0;
        settle();
        check("r_d_rvalid", bus.d_rvalid, 1);
        check("r_d_rdata",  bus.d_rdata,  32'h0022_3300);
        check("r_i_rvalid", bus.i_rvalid, 0);

        // Both ports requesting continuously: D,D,D,D,I repeating.
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (k == 0) begin
                bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2004;
            end
            settle();
            check("arb_d_gnt", bus.d_gnt, ((k % 5) != 4));
            check("arb_i_gnt", bus.i_gnt, ((k % 5) == 4));
            if (k > 0) begin
                check("arb_d_rvalid", bus.d_rvalid, prev_d);
                check("arb_i_rvalid", bus.i_rvalid, !prev_d);
                if (prev_d) check("arb_d_rdata", bus.d_rdata, 32'h0022_3300);
                else        check("arb_i_rdata", bus.i_rdata, 32'hDEADBEEF);
            end
            prev_d = ((k % 5) != 4);
        end

        // Alternating single-port reads: no cross-routing.
        for (int k = 0; k < 6; k++) begin
            cyc();
            bus.i_req = ((k % 2) == 0);
            bus.d_req = ((k % 2) == 1);
            settle();
            check("alt_i_gnt",    bus.i_gnt,    ((k % 2) == 0));
            check("alt_d_gnt",    bus.d_gnt,    ((k % 2) == 1));
            check("alt_d_rvalid", bus.d_rvalid, prev_d);
            check("alt_i_rvalid", bus.i_rvalid, !prev_d);
            if (prev_d) check("alt_d_rdata", bus.d_rdata, 32'h0022_3300);
            else        check("alt_i_rdata", bus.i_rdata, 32'hDEADBEEF);
            prev_d = ((k % 2) == 1);
        end
        cyc();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        settle();
        check("alt_last_d_rvalid", bus.d_rvalid, 1);
        check("alt_last_i_rvalid", bus.i_rvalid, 0);

        // Out-of-range data read.
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0010_0000;
        settle();
        check("oor_d_gnt",  bus.d_gnt,  1);
        check("oor_mem_en", bus.mem_en, 0);
        cyc();
        bus.d_req = 1'b0;
        settle();
        check("oor_d_rvalid", bus.d_rvalid, 1);
        check("oor_d_rdata",  bus.d_rdata,  0);
        check("oor_addr_err", bus.addr_err, 1);
        cyc();
        settle();
        check("oor_addr_err_pulse", bus.addr_err, 0);
        check("oor_d_rvalid_off",   bus.d_rvalid, 0);

        // Out-of-range write and zero-byte-enable write must leave RAM untouched.
        cyc();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
        bus.d_addr = 32'h0001_2004; bus.d_wdata = 32'hFFFF_FFFF;
        settle();
        check("oorw_d_gnt",  bus.d_gnt,  1);
        check("oorw_mem_we", bus.mem_we, 0);
        check("oorw_mem_en", bus.mem_en, 0);
        cyc();
        bus.d_be = 4'h0; bus.d_addr = 32'h0000_2004;
        settle();
        check("oorw_addr_err", bus.addr_err, 1);
        check("be0_d_gnt",     bus.d_gnt,    1);
        check("be0_mem_we",    bus.mem_we,   0);
        cyc();
        bus.d_we = 1'b0;
        settle();
        check("be0_addr_err", bus.addr_err, 0);
        check("be0_d_rvalid", bus.d_rvalid, 0);
        cyc();
        bus.d_req = 1'b0;
        settle();
        check("rb_d_rdata", bus.d_rdata, 32'h0022_3300);

        // Reset arriving while a fetch response is pending.
        cyc();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0012;
        settle();
        check("mr_i_gnt",    bus.i_gnt,    1);
        check("mr_mem_addr", bus.mem_addr, 32'h4);
        cyc();
        bus.i_req = 1'b0;
        rst = 1'b1;
        settle();
        check("mr_i_rvalid", bus.i_rvalid, 0);
        check("mr_i_rdata",  bus.i_rdata,  0);
        check("mr_d_rdata",  bus.d_rdata,  0);
        cyc();
        rst = 1'b0;
        settle();
        check("mr_post_i_rvalid", bus.i_rvalid, 0);
        check("mr_post_i_rdata",  bus.i_rdata,  0);
        cyc();
        bus.i_req = 1'b1;
        settle();
        check("mr_new_i_gnt", bus.i_gnt, 1);
        cyc();
        bus.i_req = 1'b0;
        settle();
        check("mr_new_i_rvalid", bus.i_rvalid, 1);
        check("mr_new_i_rdata",  bus.i_rdata,  32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
